// File: rtl/mcu_pkg.sv
// Shared opcode/funct constants, ALU control encodings and FSM state type
// for the multicycle MIPS control unit.
package mcu_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALU_W    = 3;
  localparam int unsigned DIVCNT_W = 8;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] F_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] F_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] F_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] F_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] F_SLT = 6'b101010;
  localparam logic [FUNCT_W-1:0] F_DIV = 6'b100001;

  localparam logic [ALU_W-1:0] ALUC_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALUC_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALUC_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALUC_DIV = 3'b011;
  localparam logic [ALU_W-1:0] ALUC_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALUC_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_RTYPE  = 4'd2,
    S_DIV    = 4'd3,
    S_ALUWB  = 4'd4,
    S_MEMADR = 4'd5,
    S_MEMRD  = 4'd6,
    S_MEMWB  = 4'd7,
    S_MEMWR  = 4'd8,
    S_BEQ    = 4'd9,
    S_ADDI   = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

endpackage

// File: rtl/mcu_alu_decoder.sv
// Combinational R-type funct decode: ALU operation plus a legal-funct flag.
module mcu_alu_decoder
  import mcu_pkg::*;
(
  input  logic [FUNCT_W-1:0] funct,
  output logic [ALU_W-1:0]   alu_ctl,
  output logic               legal
);

  always_comb begin
    alu_ctl = ALUC_ADD;
    legal   = 1'b1;
    case (funct)
      F_ADD:   alu_ctl = ALUC_ADD;
      F_SUB:   alu_ctl = ALUC_SUB;
      F_AND:   alu_ctl = ALUC_AND;
      F_OR:    alu_ctl = ALUC_OR;
      F_SLT:   alu_ctl = ALUC_SLT;
      F_DIV:   alu_ctl = ALUC_DIV;
      default: legal   = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_cu.sv
// Multicycle MIPS control unit: Moore FSM with memory wait states, divide stall
// and illegal-instruction trap. Define MULTICYCLE_CU_PERF_CNT_EN for retired_cnt.
module multicycle_cu
  import mcu_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 8,
  parameter int unsigned ALUC_W     = 3
`ifdef MULTICYCLE_CU_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W      = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              IorD,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic              PCWrite,
  output logic [1:0]        PCSrc,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [ALUC_W-1:0] ALUControl,
  output logic              RegWrite,
  output logic              RegDst,
  output logic              MemtoReg,
  output logic              illegal_instr
`ifdef MULTICYCLE_CU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  retired_cnt
`endif
);

  localparam logic [DIVCNT_W-1:0] DIV_LOAD = DIVCNT_W'(DIV_CYCLES - 1);

  state_t               state, state_nxt;
  logic [DIVCNT_W-1:0]  div_cnt;
  logic [ALU_W-1:0]     dec_ctl;
  logic                 dec_legal;

  mcu_alu_decoder u_alu_dec (
    .funct   (funct),
    .alu_ctl (dec_ctl),
    .legal   (dec_legal)
  );

  // State register and divide stall counter (loaded on entry to S_DIV)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      div_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == S_DIV && state != S_DIV)
        div_cnt <= DIV_LOAD;
      else if (state == S_DIV && div_cnt != '0)
        div_cnt <= div_cnt - DIVCNT_W'(1);
    end
  end

  // Next state and Moore outputs; everything forced low while reset is held
  always_comb begin
    state_nxt     = state;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    PCSrc         = 2'b00;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUControl    = '0;
    RegWrite      = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    illegal_instr = 1'b0;

    if (rst_n) begin
      case (state)
        S_FETCH: begin
          MemRead    = 1'b1;
          ALUSrcB    = 2'b01;
          ALUControl = ALUC_W'(ALUC_ADD);
          IRWrite    = mem_ready;
          PCWrite    = mem_ready;
          if (mem_ready) state_nxt = S_DECODE;
        end
        S_DECODE: begin
          ALUSrcB    = 2'b11;
          ALUControl = ALUC_W'(ALUC_ADD);
          case (op)
            OP_RTYPE:     state_nxt = (funct == F_DIV) ? S_DIV : S_RTYPE;
            OP_LW, OP_SW: state_nxt = S_MEMADR;
            OP_BEQ:       state_nxt = S_BEQ;
            OP_ADDI:      state_nxt = S_ADDI;
            OP_J:         state_nxt = S_JUMP;
            default:      state_nxt = S_TRAP;
          endcase
        end
        S_RTYPE: begin
          ALUSrcA    = 1'b1;
          ALUControl = ALUC_W'(dec_ctl);
          state_nxt  = dec_legal ? S_ALUWB : S_TRAP;
        end
        S_DIV: begin
          ALUSrcA    = 1'b1;
          ALUControl = ALUC_W'(ALUC_DIV);
          if (div_cnt == '0) state_nxt = S_ALUWB;
        end
        S_ALUWB: begin
          RegWrite  = 1'b1;
          RegDst    = 1'b1;
          state_nxt = S_FETCH;
        end
        S_MEMADR: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          ALUControl = ALUC_W'(ALUC_ADD);
          state_nxt  = (op == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (mem_ready) state_nxt = S_MEMWB;
        end
        S_MEMWB: begin
          RegWrite  = 1'b1;
          MemtoReg  = 1'b1;
          state_nxt = S_FETCH;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (mem_ready) state_nxt = S_FETCH;
        end
        S_BEQ: begin
          ALUSrcA    = 1'b1;
          ALUControl = ALUC_W'(ALUC_SUB);
          PCSrc      = 2'b01;
          PCWrite    = zero;
          state_nxt  = S_FETCH;
        end
        S_ADDI: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          ALUControl = ALUC_W'(ALUC_ADD);
          state_nxt  = S_ADDIWB;
        end
        S_ADDIWB: begin
          RegWrite  = 1'b1;
          state_nxt = S_FETCH;
        end
        S_JUMP: begin
          PCSrc     = 2'b10;
          PCWrite   = 1'b1;
          state_nxt = S_FETCH;
        end
        S_TRAP: begin
          illegal_instr = 1'b1;
          state_nxt     = S_FETCH;
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

`ifdef MULTICYCLE_CU_PERF_CNT_EN
  // Counts completed instructions; trapped ones return to fetch uncounted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retired_cnt <= '0;
    else if (state_nxt == S_FETCH && state != S_FETCH && state != S_TRAP)
      retired_cnt <= retired_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed self-checking bench for multicycle_cu; cycle 1 of each instruction
// is its first S_FETCH cycle, inputs driven at posedge+1, outputs sampled at +2.
module tb_multicycle_cu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       IorD, MemRead, MemWrite, IRWrite, PCWrite;
  logic [1:0] PCSrc, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst, MemtoReg, illegal_instr;
  logic [2:0] ALUControl;
`ifdef MULTICYCLE_CU_PERF_CNT_EN
  logic [31:0] retired_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int exp_retired = 0;

  multicycle_cu #(.DIV_CYCLES(8), .ALUC_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .illegal_instr(illegal_instr)
`ifdef MULTICYCLE_CU_PERF_CNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    mem_ready = 1'b1;
    #1;
    tests++; if (MemRead !== 1'b0) begin fails++; $display("FAIL reset_memread: got %b want 0", MemRead); end
    tests++; if ({IorD, MemWrite, IRWrite, PCWrite, RegWrite, RegDst, MemtoReg, illegal_instr} !== 8'b0) begin
      fails++; $display("FAIL reset_strobes: got %b want 00000000",
        {IorD, MemWrite, IRWrite, PCWrite, RegWrite, RegDst, MemtoReg, illegal_instr}); end
    tests++; if ({PCSrc, ALUSrcA, ALUSrcB, ALUControl} !== 8'b0) begin
      fails++; $display("FAIL reset_selects: got %b want 00000000", {PCSrc, ALUSrcA, ALUSrcB, ALUControl}); end
    next_cycle();
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    tests++; if ({MemRead, IorD, ALUSrcA, ALUSrcB, ALUControl} !== 8'b1000_1010) begin
      fails++; $display("FAIL fetch_after_reset: got %b want 10001010", {MemRead, IorD, ALUSrcA, ALUSrcB, ALUControl}); end
    tests++; if ({IRWrite, PCWrite} !== 2'b00) begin
      fails++; $display("FAIL fetch_wait_no_write: got %b want 00", {IRWrite, PCWrite}); end
`ifdef MULTICYCLE_CU_PERF_CNT_EN
    tests++; if (retired_cnt !== 32'd0) begin fails++; $display("FAIL reset_retired: got %0d want 0", retired_cnt); end
`endif
    next_cycle();
  endtask

  // lw: fetch stalls 2 cycles, memory read stalls 3 cycles
  task automatic test_lw_wait_states;
    int ir_cnt = 0, rw_cnt = 0, mw_cnt = 0, rw_cycle = 0;
    int exp_rw_cycle = (2 + 1) + 1 + 1 + (3 + 1) + 1;
    op = 6'b100011; funct = 6'b000000; zero = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      mem_ready = (c == 3 || c == 9);
      #1;
      if (IRWrite) ir_cnt++;
      if (MemWrite) mw_cnt++;
      if (RegWrite) begin rw_cnt++; if (rw_cycle == 0) rw_cycle = c; end
      if (c == 6) begin
        tests++; if ({MemRead, IorD} !== 2'b11) begin fails++; $display("FAIL lw_memrd: got %b want 11", {MemRead, IorD}); end
      end
      if (c == 10) begin
        tests++; if ({RegWrite, MemtoReg, RegDst} !== 3'b110) begin
          fails++; $display("FAIL lw_memwb: got %b want 110", {RegWrite, MemtoReg, RegDst}); end
      end
      if (c == 11) begin
        tests++; if ({MemRead, IorD, RegWrite} !== 3'b100) begin
          fails++; $display("FAIL lw_back_to_fetch: got %b want 100", {MemRead, IorD, RegWrite}); end
      end
      next_cycle();
    end
    tests++; if (ir_cnt !== 1) begin fails++; $display("FAIL lw_irwrite_count: got %0d want 1", ir_cnt); end
    tests++; if (rw_cycle !== exp_rw_cycle || rw_cnt !== 1) begin
      fails++; $display("FAIL lw_regwrite_cycle: got cycle %0d count %0d want cycle %0d count 1", rw_cycle, rw_cnt, exp_rw_cycle); end
    tests++; if (mw_cnt !== 0) begin fails++; $display("FAIL lw_no_memwrite: got %0d want 0", mw_cnt); end
    exp_retired++;
`ifdef MULTICYCLE_CU_PERF_CNT_EN
    tests++; if (retired_cnt !== 32'(exp_retired)) begin fails++; $display("FAIL lw_retired: got %0d want %0d", retired_cnt, exp_retired); end
`endif
  endtask

  task automatic test_rtype_add;
    op = 6'b000000; funct = 6'b100000;
    for (int c = 1; c <= 5; c++) begin
      mem_ready = (c != 5);
      #1;
      if (c == 3) begin
        tests++; if ({ALUControl, ALUSrcA, ALUSrcB} !== 6'b010_1_00) begin
          fails++; $display("FAIL add_rtype: got %b want 010100", {ALUControl, ALUSrcA, ALUSrcB}); end
      end
      if (c == 4) begin
        tests++; if ({RegWrite, RegDst, MemtoReg} !== 3'b110) begin
          fails++; $display("FAIL add_aluwb: got %b want 110", {RegWrite, RegDst, MemtoReg}); end
      end
      if (c == 5) begin
        tests++; if ({MemRead, ALUSrcB, RegWrite} !== 4'b1010) begin
          fails++; $display("FAIL add_fetch: got %b want 1010", {MemRead, ALUSrcB, RegWrite}); end
      end
      next_cycle();
    end
    exp_retired++;
  endtask

  task automatic test_div_stall;
    int div_cnt = 0, first_div = 0, rw_cnt = 0, rw_cycle = 0;
    op = 6'b000000; funct = 6'b100001;
    for (int c = 1; c <= 12; c++) begin
      mem_ready = (c != 12);
      #1;
      if (ALUControl === 3'b011) begin div_cnt++; if (first_div == 0) first_div = c; end
      if (RegWrite) begin rw_cnt++; rw_cycle = c; end
      next_cycle();
    end
    tests++; if (div_cnt !== 8 || first_div !== 3) begin
      fails++; $display("FAIL div_cycles: got %0d from cycle %0d want 8 from cycle 3", div_cnt, first_div); end
    tests++; if (rw_cnt !== 1 || rw_cycle !== 11) begin
      fails++; $display("FAIL div_writeback: got count %0d cycle %0d want count 1 cycle 11", rw_cnt, rw_cycle); end
    exp_retired++;
  endtask

  task automatic test_beq;
    logic [2:0] exp_pc;
    op = 6'b000100; funct = 6'b000000;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      exp_pc = {z[0], 2'b01};
      for (int c = 1; c <= 4; c++) begin
        mem_ready = (c != 4);
        #1;
        if (c == 3) begin
          tests++; if ({PCWrite, PCSrc} !== exp_pc || ALUControl !== 3'b110) begin
            fails++; $display("FAIL beq_zero%0d: got pcw/pcsrc %b alu %b want %b alu 110", z, {PCWrite, PCSrc}, ALUControl, exp_pc); end
        end
        next_cycle();
      end
      exp_retired++;
    end
    zero = 1'b0;
  endtask

  task automatic test_jump_addi;
    op = 6'b000010;
    for (int c = 1; c <= 4; c++) begin
      mem_ready = (c != 4);
      #1;
      if (c == 3) begin
        tests++; if ({PCWrite, PCSrc} !== 3'b110) begin fails++; $display("FAIL jump: got %b want 110", {PCWrite, PCSrc}); end
      end
      next_cycle();
    end
    op = 6'b001000;
    for (int c = 1; c <= 5; c++) begin
      mem_ready = (c != 5);
      #1;
      if (c == 3) begin
        tests++; if ({ALUSrcA, ALUSrcB, ALUControl} !== 6'b1_10_010) begin
          fails++; $display("FAIL addi_exec: got %b want 110010", {ALUSrcA, ALUSrcB, ALUControl}); end
      end
      if (c == 4) begin
        tests++; if ({RegWrite, RegDst, MemtoReg} !== 3'b100) begin
          fails++; $display("FAIL addi_wb: got %b want 100", {RegWrite, RegDst, MemtoReg}); end
      end
      next_cycle();
    end
    exp_retired += 2;
  endtask

  task automatic test_illegal;
    int ill_cnt, ill_cycle, wr_cnt;
    for (int k = 0; k < 2; k++) begin
      int n = (k == 0) ? 4 : 5;
      int exp_cycle = (k == 0) ? 3 : 4;
      ill_cnt = 0; ill_cycle = 0; wr_cnt = 0;
      if (k == 0) begin op = 6'b111111; funct = 6'b100000; end
      else begin op = 6'b000000; funct = 6'b000111; end
      for (int c = 1; c <= n; c++) begin
        mem_ready = (c != n);
        #1;
        if (illegal_instr) begin ill_cnt++; ill_cycle = c; end
        if (RegWrite || MemWrite) wr_cnt++;
        next_cycle();
      end
      tests++; if (ill_cnt !== 1 || ill_cycle !== exp_cycle) begin
        fails++; $display("FAIL illegal_pulse%0d: got count %0d cycle %0d want count 1 cycle %0d", k, ill_cnt, ill_cycle, exp_cycle); end
      tests++; if (wr_cnt !== 0) begin fails++; $display("FAIL illegal_nowrite%0d: got %0d want 0", k, wr_cnt); end
    end
`ifdef MULTICYCLE_CU_PERF_CNT_EN
    tests++; if (retired_cnt !== 32'(exp_retired)) begin fails++; $display("FAIL retired_after_traps: got %0d want %0d", retired_cnt, exp_retired); end
`endif
  endtask

  // sw stalled in S_MEMWR, then reset aborts it
  task automatic test_sw_reset_abort;
    op = 6'b101011; funct = 6'b000000;
    for (int c = 1; c <= 5; c++) begin
      mem_ready = (c == 1);
      #1;
      if (c == 4 || c == 5) begin
        tests++; if ({MemWrite, IorD, MemRead} !== 3'b110) begin
          fails++; $display("FAIL sw_memwr_hold%0d: got %b want 110", c, {MemWrite, IorD, MemRead}); end
      end
      if (c < 5) next_cycle();
    end
    rst_n = 1'b0;
    #1;
    tests++; if ({MemWrite, RegWrite, MemRead} !== 3'b000) begin
      fails++; $display("FAIL sw_async_abort: got %b want 000", {MemWrite, RegWrite, MemRead}); end
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    tests++; if ({MemRead, IorD, ALUSrcB, MemWrite} !== 5'b10010) begin
      fails++; $display("FAIL sw_fetch_after_abort: got %b want 10010", {MemRead, IorD, ALUSrcB, MemWrite}); end
`ifdef MULTICYCLE_CU_PERF_CNT_EN
    tests++; if (retired_cnt !== 32'd0) begin fails++; $display("FAIL sw_retired_cleared: got %0d want 0", retired_cnt); end
`endif
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    next_cycle();
    next_cycle();
    test_reset();
    test_lw_wait_states();
    test_rtype_add();
    test_div_stall();
    test_beq();
    test_jump_addi();
    test_illegal();
    test_sw_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
